// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default
// reset PC and the sequential PC increment.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } fetch_state_e;

    // BIOS entry point
    localparam logic [31:0] DefaultResetPc = 32'h4000_0000;
    localparam logic [31:0] PcIncr         = 32'd4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: redirect/stall from the pipeline, imem request/response,
// IF/ID slot outputs and performance counters.
// master = fetch sequencer side, slave = environment (imem + pipeline).
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_redir_cnt;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, perf_stall_cnt, perf_redir_cnt
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, perf_stall_cnt, perf_redir_cnt
    );
endinterface

// File: rtl/fetch_sequencer_perf_counters.sv
// Two free-running 32-bit event counters (stall cycles, redirects) with a
// synchronous active-low clear. Both wrap at 2^32.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_evt_i,
    input  logic        redir_evt_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] redir_cnt_o
);
    logic [31:0] stall_cnt_q, redir_cnt_q;

    // Count events; cleared while rst is low
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            if (stall_evt_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redir_evt_i) redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign redir_cnt_o = redir_cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues at most one outstanding imem
// request, fills the IF/ID slot and applies execute-stage redirects.
// Optional macro FETCH_SEQ_PERF_EN adds stall/redirect performance counters;
// without it the perf outputs are tied to zero.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc)
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, req_pc_q, if_pc_q;
    logic [31:0]       if_instr_q;
    logic              if_valid_q;

    logic              imem_req;
    logic              req_fire;
    logic [ADDR_W-1:0] redir_pc;
    logic              unused_redir_lsb;

    // Hold off new requests while a live instruction is stalled in IF/ID, so a
    // response can never land on top of it.
    assign imem_req = (state_q == StReq) && (!if_valid_q || !bus.stall);
    assign req_fire = imem_req && bus.imem_ready;
    assign redir_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_pc[1:0];

    // Fetch FSM, PC and IF/ID slot; redirect takes priority over stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= '0;
        end else if (bus.redirect_valid) begin
            pc_q       <= redir_pc;
            if_valid_q <= 1'b0;
            unique case (state_q)
                StIdle:  state_q <= StReq;
                StReq:   state_q <= req_fire ? StDrain : StReq;
                // A response arriving now retires the outstanding request, so
                // there is nothing left to drain.
                StWait,
                StDrain: state_q <= bus.imem_rvalid ? StReq : StDrain;
                default: state_q <= StIdle;
            endcase
        end else begin
            if (!bus.stall) if_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (req_fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + ADDR_W'(PcIncr);
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid) begin
                        if_valid_q <= 1'b1;
                        if_instr_q <= bus.imem_rdata;
                        if_pc_q    <= req_pc_q;
                        state_q    <= StReq;
                    end
                end
                StDrain: begin
                    if (bus.imem_rvalid) state_q <= StReq;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = {pc_q[ADDR_W-1:2], 2'b00};
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;

`ifdef FETCH_SEQ_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_evt_i (if_valid_q && bus.stall),
        .redir_evt_i (bus.redirect_valid),
        .stall_cnt_o (bus.perf_stall_cnt),
        .redir_cnt_o (bus.perf_redir_cnt)
    );
`else
    assign bus.perf_stall_cnt = 32'd0;
    assign bus.perf_redir_cnt = 32'd0;
`endif
endmodule
